// File: rtl/regwb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package regwb_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_REG     = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// scanning from ptr upward (mod N). The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx
);

  int   cand;
  logic found;

  // Rotating priority scan starting at ptr.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for register_file: clears every register after
// reset, then round-robin arbitrates writeback requesters onto the port.
// Optional write-to-read forwarding ports are built when REGWB_FWD_EN is defined.
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = regwb_pkg::DEF_DATA_W,
  parameter int ADDR_W   = regwb_pkg::DEF_ADDR_W,
  parameter int NUM_REGS = regwb_pkg::DEF_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      reg_write_en,
  output logic [ADDR_W-1:0]         reg_write_dest,
  output logic [DATA_W-1:0]         reg_write_data,
  output logic                      init_done
`ifdef REGWB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         reg_read_addr_1,
  input  logic [ADDR_W-1:0]         reg_read_addr_2,
  output logic                      fwd_valid_1,
  output logic                      fwd_valid_2,
  output logic [DATA_W-1:0]         fwd_data_1,
  output logic [DATA_W-1:0]         fwd_data_2
`endif
);

  import regwb_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_t              state;
  logic [CNT_W-1:0]    clr_cnt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    rr_nxt;
  logic [NUM_REQ-1:0]  gnt;
  logic                accept;
  logic [ADDR_W-1:0]   sel_dest;
  logic [DATA_W-1:0]   sel_data;
  logic                we_q;
  logic [ADDR_W-1:0]   dest_q;
  logic [DATA_W-1:0]   data_q;
  logic                done_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Grants only exist in RUN and never while reset is held.
  assign req_ready = (state == ST_RUN && !rst) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_dest  = req_dest[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
  assign rr_nxt    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Reset wins over a write registered in the previous cycle.
  assign reg_write_en   = we_q & ~rst;
  assign reg_write_dest = rst ? '0 : dest_q;
  assign reg_write_data = rst ? '0 : data_q;
  assign init_done      = done_q & ~rst;

  // Clear sequence, then arbitration with a one-cycle write latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      rr_ptr  <= '0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          we_q   <= 1'b1;
          dest_q <= ADDR_W'(clr_cnt);
          data_q <= '0;
          if (clr_cnt == CNT_W'(NUM_REGS - 1)) begin
            state  <= ST_RUN;
            done_q <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            rr_ptr <= rr_nxt;
            dest_q <= sel_dest;
            data_q <= sel_data;
            we_q   <= (sel_dest != ADDR_W'(ZERO_REG));
          end else begin
            we_q <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

`ifdef REGWB_FWD_EN
  // Bypass the value being written this cycle to matching read ports.
  assign fwd_valid_1 = reg_write_en && (reg_write_dest == reg_read_addr_1) &&
                       (reg_read_addr_1 != ADDR_W'(ZERO_REG));
  assign fwd_valid_2 = reg_write_en && (reg_write_dest == reg_read_addr_2) &&
                       (reg_read_addr_2 != ADDR_W'(ZERO_REG));
  assign fwd_data_1  = fwd_valid_1 ? reg_write_data : '0;
  assign fwd_data_2  = fwd_valid_2 ? reg_write_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (default 3 requesters, 32x32).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_dest;
  logic [95:0] req_data;
  logic        reg_write_en;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic        init_done;
  logic [4:0]  d [3];
  logic [31:0] x [3];
`ifdef REGWB_FWD_EN
  logic [4:0]  rd1, rd2;
  logic        fv1, fv2;
  logic [31:0] fd1, fd2;
`endif

  assign req_dest = {d[2], d[1], d[0]};
  assign req_data = {x[2], x[1], x[0]};

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dest       (req_dest),
    .req_data       (req_data),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .init_done      (init_done)
`ifdef REGWB_FWD_EN
    ,
    .reg_read_addr_1 (rd1),
    .reg_read_addr_2 (rd2),
    .fwd_valid_1     (fv1),
    .fwd_valid_2     (fv2),
    .fwd_data_1      (fd1),
    .fwd_data_2      (fd2)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  logic [2:0]  last_ready;
  logic [2:0]  last_acc;
  int          wait_cnt [3];
  int          max_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid requester in rotation order starting at ptr.
  function automatic logic [2:0] model_grant(input logic [2:0] val, input int ptr);
    for (int k = 0; k < 3; k++)
      if (val[(ptr + k) % 3]) return 3'b001 << ((ptr + k) % 3);
    return 3'b000;
  endfunction

  // One RUN cycle: check the grant, clock, then check the write port.
  task automatic do_cycle();
    logic [2:0]  eg;
    logic [4:0]  gd;
    logic [31:0] gx;
    int          g;
    #1;
    eg = model_grant(req_valid, m_ptr);
    check("ready", {61'd0, req_ready}, {61'd0, eg});
    last_ready = req_ready;
    for (int i = 0; i < 3; i++) begin
      if (req_valid[i] && !req_ready[i]) wait_cnt[i]++;
      else wait_cnt[i] = 0;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
    g = 0;
    for (int i = 0; i < 3; i++) if (eg[i]) g = i;
    gd = d[g];
    gx = x[g];
    @(posedge clk); #1;
    if (eg != 3'b000) begin
      m_ptr  = (g + 1) % 3;
      m_we   = (gd != 5'd0);
      m_dest = gd;
      m_data = gx;
    end else begin
      m_we = 1'b0;
    end
    last_acc = eg;
    check("wr_en",   {63'd0, reg_write_en},   {63'd0, m_we});
    check("wr_dest", {59'd0, reg_write_dest}, {59'd0, m_dest});
    check("wr_data", {32'd0, reg_write_data}, {32'd0, m_data});
  endtask

  // Expect 32 clear writes; requesters are held valid to prove no grant leaks.
  task automatic check_clear();
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      check("clr_en",   {63'd0, reg_write_en},   64'd1);
      check("clr_dest", {59'd0, reg_write_dest}, 64'(k));
      check("clr_data", {32'd0, reg_write_data}, 64'd0);
      check("clr_done", {63'd0, init_done},      (k == 31) ? 64'd1 : 64'd0);
      if (k < 31) check("clr_ready", {61'd0, req_ready}, 64'd0);
    end
    req_valid = 3'b000;
    m_ptr  = 0;
    m_we   = 1'b1;
    m_dest = 5'd31;
    m_data = 32'd0;
  endtask

  logic [2:0] t3_ord [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  int         t3_idx [5] = '{0, 1, 2, 0, 1};

  initial begin
    max_wait = 0;
    for (int i = 0; i < 3; i++) begin
      wait_cnt[i] = 0;
      d[i] = 5'($urandom_range(1, 31));
      x[i] = $urandom;
    end
    last_acc  = 3'b000;
    rst       = 1'b1;
    req_valid = 3'b111;
`ifdef REGWB_FWD_EN
    rd1 = 5'd0;
    rd2 = 5'd0;
`endif

    // Reset state
    @(posedge clk); #1;
    check("rst_en",    {63'd0, reg_write_en},   64'd0);
    check("rst_dest",  {59'd0, reg_write_dest}, 64'd0);
    check("rst_data",  {32'd0, reg_write_data}, 64'd0);
    check("rst_done",  {63'd0, init_done},      64'd0);
    check("rst_ready", {61'd0, req_ready},      64'd0);
    rst = 1'b0;
    #1;
    check("clr0_ready", {61'd0, req_ready}, 64'd0);
    check_clear();

    // Single requester 1, dest 3, data 10
    req_valid = 3'b010; d[1] = 5'd3; x[1] = 32'd10;
    do_cycle();
    check("t2_ready", {61'd0, last_ready}, 64'b010);
    check("t2_en",   {63'd0, reg_write_en},   64'd1);
    check("t2_dest", {59'd0, reg_write_dest}, 64'd3);
    check("t2_data", {32'd0, reg_write_data}, 64'd10);
    req_valid = 3'b000;
    do_cycle();
    check("t2_idle", {63'd0, reg_write_en}, 64'd0);

    // Bring pointer back to 0 via requester 2, then all three valid
    req_valid = 3'b100; d[2] = 5'd9; x[2] = 32'h55;
    do_cycle();
    for (int i = 0; i < 3; i++) begin
      d[i] = 5'(i + 1);
      x[i] = 32'(100 + i);
    end
    req_valid = 3'b111;
    for (int j = 0; j < 5; j++) begin
      do_cycle();
      check("t3_grant", {61'd0, last_ready}, {61'd0, t3_ord[j]});
      check("t3_data",  {32'd0, reg_write_data}, 64'(100 + t3_idx[j]));
    end

    // Pointer back to 0, then a write to $zero
    req_valid = 3'b100;
    do_cycle();
    req_valid = 3'b001; d[0] = 5'd0; x[0] = 32'hDEAD;
    do_cycle();
    check("t4_ready", {61'd0, last_ready},   64'b001);
    check("t4_en",    {63'd0, reg_write_en}, 64'd0);
    req_valid = 3'b111; d[0] = 5'd4;
    #1;
    check("t4_ptr", {61'd0, req_ready}, 64'b010);
    req_valid = 3'b000;
    do_cycle();

    // Reset right after requester 2 is accepted with dest 7
    req_valid = 3'b100; d[2] = 5'd7; x[2] = 32'h77;
    do_cycle();
    req_valid = 3'b000;
    rst = 1'b1;
    #1;
    check("t5_en",    {63'd0, reg_write_en},   64'd0);
    check("t5_dest",  {59'd0, reg_write_dest}, 64'd0);
    check("t5_data",  {32'd0, reg_write_data}, 64'd0);
    check("t5_done",  {63'd0, init_done},      64'd0);
    @(posedge clk); #1;
    check("t5_en2",   {63'd0, reg_write_en},   64'd0);
    check("t5_ready", {61'd0, req_ready},      64'd0);
    req_valid = 3'b111;
    rst = 1'b0;
    #1;
    check("t5_clr_ready", {61'd0, req_ready}, 64'd0);
    check_clear();

    // Randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || last_acc[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 65);
          d[i] = 5'($urandom_range(0, 31));
          x[i] = $urandom;
        end else if ($urandom_range(0, 99) < 5) begin
          req_valid[i] = 1'b0;
        end
      end
      do_cycle();
    end
    check("fairness", 64'(max_wait <= 2), 64'd1);

`ifdef REGWB_FWD_EN
    req_valid = 3'b001; d[0] = 5'd5; x[0] = 32'd7;
    do_cycle();
    req_valid = 3'b000;
    rd1 = 5'd5; rd2 = 5'd0;
    #1;
    check("fwd_v1", {63'd0, fv1}, 64'd1);
    check("fwd_d1", {32'd0, fd1}, 64'd7);
    check("fwd_v2", {63'd0, fv2}, 64'd0);
    check("fwd_d2", {32'd0, fd2}, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
